cnn_bit_packer_tx: RTL

Result-side serializer for the CNN datapath. It is the inverse of the input unpacker, which spreads each received UART byte into 8 single-bit RAM writes, LSB first. This block collects a stream of 1-bit results, packs them 8 per byte LSB-first, and buffers bytes in a small FIFO. It then drives the UART transmitter with the trmt/tx_done handshake, one byte at a time, and tags the end of each frame.

---
 rtl/cnn_bit_packer_tx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cnn_bit_packer_tx.sv
// rtl/cnn_bit_packer_tx.sv - packs 1-bit CNN results LSB-first into bytes and feeds the UART transmitter
//
// Purpose: collects a stream of result bits, packs 8 per byte (LSB first),
// zero-pads the final byte of each FRAME_BITS-bit frame, buffers bytes in a
// DEPTH-entry FIFO tagged with an end-of-frame flag, and hands them to the
// UART one at a time with the trmt/tx_done handshake.
//
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   clr      - synchronous clear, aborts the current frame
//   bit_vld  - bit_in is valid this cycle
//   bit_in   - result bit
//   rdy      - bit accepted when bit_vld && rdy
//   tx_done  - one-cycle pulse from UART: byte finished
//   trmt     - one-cycle pulse: start transmitting tx_data
//   tx_data  - byte to transmit, held from trmt until tx_done
//   frm_done - one-cycle pulse: last byte of the frame transmitted
module cnn_bit_packer_tx #(
   parameter int FRAME_BITS = 676,
   parameter int DEPTH      = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       bit_vld,
   input  logic       bit_in,
   output logic       rdy,
   input  logic       tx_done,
   output logic       trmt,
   output logic [7:0] tx_data,
   output logic       frm_done
);

   localparam int FW = $clog2(FRAME_BITS + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [FW-1:0] LAST_IDX = FW'(FRAME_BITS - 1);

   typedef enum logic {IDLE, WAIT} state_t;
   state_t state, state_nxt;

   logic [2:0]    cnt_8;
   logic [7:0]    pk;
   logic [FW-1:0] fcnt;
   logic [8:0]    mem [DEPTH];
   logic [AW:0]   wptr, rptr, wptr_nxt, rptr_nxt;
   logic          full, full_nxt, empty;
   logic          accept, last_bit, push, pop, last_r;
   logic [7:0]    keep, push_byte;

   assign rdy      = !full;
   assign empty    = (wptr == rptr);
   assign accept   = bit_vld && !full && !clr;
   assign last_bit = (fcnt == LAST_IDX);
   assign push     = accept && ((cnt_8 == 3'd7) || last_bit);

   // keep masks off every position above the bit being inserted, which
   // zero-pads a short final byte
   assign keep      = 8'hFF >> (3'd7 - cnt_8);
   assign push_byte = (pk | (8'(bit_in) << cnt_8)) & keep;

   // the extra pointer bit distinguishes full from empty when indices match
   assign wptr_nxt = wptr + (AW+1)'(push);
   assign rptr_nxt = rptr + (AW+1)'(pop);
   assign full_nxt = (wptr_nxt[AW] != rptr_nxt[AW]) &&
                     (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      if (clr) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  pop       = 1'b1;
                  state_nxt = WAIT;
               end
            end
            WAIT: begin
               if (tx_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         trmt     <= 1'b0;
         frm_done <= 1'b0;
         tx_data  <= 8'h00;
         last_r   <= 1'b0;
      end else begin
         state    <= state_nxt;
         trmt     <= pop;
         frm_done <= !clr && (state == WAIT) && tx_done && last_r;
         if (clr) begin
            last_r <= 1'b0;
         end else if (pop) begin
            tx_data <= mem[rptr[AW-1:0]][7:0];
            last_r  <= mem[rptr[AW-1:0]][8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_8 <= 3'd0;
         pk    <= 8'h00;
         fcnt  <= '0;
         wptr  <= '0;
         rptr  <= '0;
         full  <= 1'b0;
      end else if (clr) begin
         cnt_8 <= 3'd0;
         pk    <= 8'h00;
         fcnt  <= '0;
         wptr  <= '0;
         rptr  <= '0;
         full  <= 1'b0;
      end else begin
         wptr <= wptr_nxt;
         rptr <= rptr_nxt;
         full <= full_nxt;
         if (accept) begin
            if (push) begin
               pk    <= 8'h00;
               cnt_8 <= 3'd0;
            end else begin
               pk[cnt_8] <= bit_in;
               cnt_8     <= cnt_8 + 3'd1;
            end
            fcnt <= last_bit ? '0 : fcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= {last_bit, push_byte};
   end

endmodule
